// File: rtl/ps2_kbd_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver and the bus decoder.
package ps2_kbd_rx_pkg;

  localparam int unsigned SCAN_W = 8;

  // Bits [31:8] of the CPU address for the ffffd000-ffffdfff window; the low nibble is don't-care.
  localparam logic [23:0] PS2_BUS_BASE = 24'hffffd0;
  localparam logic [23:0] PS2_BUS_MASK = 24'hfffff0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

endpackage

// File: rtl/sync_fifo_byte.sv
// Byte-wide synchronous FIFO with combinational head read.
module sync_fifo_byte
  import ps2_kbd_rx_pkg::*;
#(
  parameter int unsigned AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [SCAN_W-1:0] din,
  input  logic              pop,
  output logic [SCAN_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [SCAN_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_pop;
  logic              do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still succeeds.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only visible through head when count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard frame receiver feeding a scan-code FIFO for the IO bus.
module ps2_kbd_rx
  import ps2_kbd_rx_pkg::*;
#(
  parameter int unsigned FIFO_AW = 3,
  parameter logic [15:0] TIMEOUT = 16'd5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              rd,
  output logic [SCAN_W-1:0] key,
  output logic              ready,
  output logic              overflow,
  output logic              frame_err
);

  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic rd_q;
  logic fall;
  logic pop_ok;

  ps2_state_e        state, state_n;
  logic [SCAN_W-1:0] shreg, shreg_n;
  logic [2:0]        bitcnt, bitcnt_n;
  logic              parity, parity_n;
  logic [15:0]       timer, timer_n;
  logic              overflow_n;
  logic              frame_err_n;
  logic              push_c;

  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_AW:0]  fifo_count;

  assign fall   = clk_prev & ~clk_s2;
  assign pop_ok = rd & ~rd_q & ~fifo_empty;
  assign ready  = (fifo_count != '0);

  // Pin synchronisers, falling-edge history and read-strobe edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      rd_q     <= 1'b0;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
      rd_q     <= rd;
    end
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      parity    <= 1'b0;
      timer     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bitcnt    <= bitcnt_n;
      parity    <= parity_n;
      timer     <= timer_n;
      overflow  <= overflow_n;
      frame_err <= frame_err_n;
    end
  end

  // Next-state: advance one bit per ps2_clk fall, abandon stalled frames.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    bitcnt_n    = bitcnt;
    parity_n    = parity;
    timer_n     = timer;
    overflow_n  = overflow;
    frame_err_n = frame_err;
    push_c      = 1'b0;

    if (state == IDLE || fall) timer_n = '0;
    else                       timer_n = timer + 16'd1;

    if (fall) begin
      case (state)
        IDLE: begin
          if (!data_s2) begin
            state_n  = DATA;
            bitcnt_n = '0;
          end else begin
            frame_err_n = 1'b1;
          end
        end
        DATA: begin
          shreg_n = {data_s2, shreg[SCAN_W-1:1]};
          if (bitcnt == 3'd7) state_n  = PARITY;
          else                bitcnt_n = bitcnt + 3'd1;
        end
        PARITY: begin
          parity_n = data_s2;
          state_n  = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if ((^{shreg, parity}) && data_s2) begin
            if (fifo_full && !pop_ok) overflow_n = 1'b1;
            else                      push_c     = 1'b1;
          end else begin
            frame_err_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && timer == TIMEOUT - 16'd1) begin
      state_n     = IDLE;
      shreg_n     = '0;
      bitcnt_n    = '0;
      frame_err_n = 1'b1;
    end
  end

  sync_fifo_byte #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .din   (shreg),
    .pop   (pop_ok),
    .head  (key),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed self-checking bench for ps2_kbd_rx.
module tb_ps2_kbd_rx;

  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rd;
  logic [7:0] key;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int total = 0;
  int bad   = 0;
  int lat;

  ps2_kbd_rx #(.FIFO_AW(3), .TIMEOUT(16'd100)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd        (rd),
    .key       (key),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Full frame; optionally corrupt parity, pulse rd to coincide with the push, or time the push.
  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            input logic pop_at_stop, input logic measure);
    logic [9:0] fr;
    fr = {(~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(fr[i]);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    if (pop_at_stop) begin
      repeat (2) @(negedge clk);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
    end
    if (measure) begin
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (ready) begin lat = k; break; end
      end
    end
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (ready !== 1'b0)     begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    total++; if (key !== 8'h00)      begin bad++; $display("FAIL reset_key got=%h exp=00", key); end
    total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
  endtask

  task automatic test_single();
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
    total++; if (lat !== 3)          begin bad++; $display("FAIL single_latency got=%0d exp=3", lat); end
    total++; if (ready !== 1'b1)     begin bad++; $display("FAIL single_ready got=%b exp=1", ready); end
    total++; if (key !== 8'h1C)      begin bad++; $display("FAIL single_key got=%h exp=1c", key); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL single_frame_err got=%b exp=0", frame_err); end
    pop_one();
    total++; if (ready !== 1'b0)     begin bad++; $display("FAIL single_pop_ready got=%b exp=0", ready); end
    total++; if (key !== 8'h00)      begin bad++; $display("FAIL single_pop_key got=%h exp=00", key); end
  endtask

  task automatic test_parity();
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    total++; if (ready !== 1'b0)     begin bad++; $display("FAIL parity_ready got=%b exp=0", ready); end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL parity_frame_err got=%b exp=1", frame_err); end
    total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL parity_overflow got=%b exp=0", overflow); end
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    total++; if (ready !== 1'b1)     begin bad++; $display("FAIL parity_next_ready got=%b exp=1", ready); end
    total++; if (key !== 8'hF0)      begin bad++; $display("FAIL parity_next_key got=%h exp=f0", key); end
    pop_one();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    for (int i = 1; i <= 8; i++) begin
      total++; if (key !== 8'(i)) begin bad++; $display("FAIL ovf_key%0d got=%h exp=%h", i, key, 8'(i)); end
      pop_one();
    end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", ready); end
  endtask

  task automatic test_held_read();
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0);
    send_frame(8'hBB, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++; if (key !== 8'hBB || ready !== 1'b1)
        begin bad++; $display("FAIL held_cyc%0d key=%h ready=%b exp key=bb ready=1", i, key, ready); end
    end
    rd = 1'b0;
    @(negedge clk);
    total++; if (key !== 8'hBB) begin bad++; $display("FAIL held_release_key got=%h exp=bb", key); end
    pop_one();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL held_drain_ready got=%b exp=0", ready); end
  endtask

  task automatic test_reset_mid();
    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (ready !== 1'b0)     begin bad++; $display("FAIL rstmid_ready got=%b exp=0", ready); end
    total++; if (key !== 8'h00)      begin bad++; $display("FAIL rstmid_key got=%h exp=00", key); end
    total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL rstmid_overflow got=%b exp=0", overflow); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_frame_err got=%b exp=0", frame_err); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rstmid_after_ready got=%b exp=0", ready); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b0, 1'b0);
    total++; if (key !== 8'h11) begin bad++; $display("FAIL full_head got=%h exp=11", key); end
    send_frame(8'h19, 1'b0, 1'b1, 1'b0);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_pp_overflow got=%b exp=0", overflow); end
    for (int i = 0; i < 8; i++) begin
      total++; if (key !== 8'h12 + 8'(i))
        begin bad++; $display("FAIL full_pp_key%0d got=%h exp=%h", i, key, 8'h12 + 8'(i)); end
      pop_one();
    end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL full_pp_empty got=%b exp=0", ready); end
  endtask

  task automatic test_timeout();
    do_reset();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b exp=0", frame_err); end
    repeat (300) @(negedge clk);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL tmo_frame_err got=%b exp=1", frame_err); end
    total++; if (ready !== 1'b0)     begin bad++; $display("FAIL tmo_ready got=%b exp=0", ready); end
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL tmo_next_ready got=%b exp=1", ready); end
    total++; if (key !== 8'h5A)  begin bad++; $display("FAIL tmo_next_key got=%h exp=5a", key); end
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd = 1'b0;
    test_reset();
    test_single();
    test_parity();
    test_overflow();
    test_held_read();
    test_reset_mid();
    test_full_push_pop();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
PS/2 keyboard receiver with a small scan-code FIFO. It sits directly upstream of the memory/IO bus decoder and supplies the bus's key[7:0] and ps2_ready inputs. It consumes the bus's ps2_rd strobe, which the decoder asserts for CPU reads in ffffd000–ffffdfff. It deserialises 11-bit PS/2 frames from the keyboard pins, validates them, and queues the scan-code bytes.

Parameters:
FIFO_AW, 3, log2 of FIFO depth (default 8 entries)
TIMEOUT, 16'd5000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock pin, asynchronous to clk
ps2_data  in  1  raw PS/2 data pin, asynchronous to clk
rd  in  1  read strobe from bus decoder (ps2_rd); may stay high for many cycles
key  out  8  scan code at FIFO head; 8'h00 when empty
ready  out  1  FIFO non-empty (ps2_ready)
overflow  out  1  sticky: a valid frame was dropped because the FIFO was full
frame_err  out  1  sticky: a frame failed the start, parity or stop check, or timed out

Behaviour:
- Reset: clk is clk; rst is asynchronous, active-high. All state clears: FSM=IDLE, pointers and count=0, sync flops=1, key=0, ready=0, overflow=0, frame_err=0.
- Synchronisation:
  - ps2_clk and ps2_data each pass through 2 flops, plus one extra flop on clk for edge detection.
  - fall = clk_prev & ~clk_sync. Data is sampled from the synchronised data flop in the cycle fall is high.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on cycles where fall=1, except the timeout.
  - IDLE: if data=0 (start bit), go to DATA with bitcnt=0. If data=1, stay in IDLE and set frame_err.
  - DATA: shift the sampled bit in LSB-first (shreg <= {d, shreg[7:1]}), bitcnt++. After the 8th bit, go to PARITY.
  - PARITY: store the parity bit; go to STOP.
  - STOP: frame is valid iff ^{shreg, parity}==1 (odd parity) and stop bit==1.
    - Valid and FIFO not full: push shreg.
    - Valid and FIFO full: drop the byte and set overflow.
    - Invalid: drop the byte and set frame_err.
    - Always return to IDLE.
- Timeout:
  - The counter resets on every fall and holds at 0 in IDLE.
  - When it reaches TIMEOUT-1 in any non-IDLE state: go to IDLE, discard the partial byte, set frame_err.
- Read handshake:
  - Pop on the rising edge of rd only: rd & ~rd_q, with rd_q registered.
  - A pop while empty is ignored with no side effects.
  - Holding rd high pops exactly one entry.
- Simultaneous push and pop in the same cycle: both take effect and count is unchanged. When the FIFO is full, a pop and a push in the same cycle both succeed and overflow is not set (the pop frees the slot first).
- Outputs:
  - key = mem[rd_ptr] when count!=0, else 8'h00. This is a combinational read of the register array.
  - ready = (count!=0), taken from a registered count.
  - Both reflect a push or pop on the cycle after the push/pop edge.
- Latency: a byte is visible on key/ready 1 clk after the cycle in which the stop-bit fall is detected (about 3 clk after the pin edge, due to synchronisation).
- Pointers are FIFO_AW bits wide and wrap naturally. count is FIFO_AW+1 bits; full = count==2**FIFO_AW.
- Sticky flags clear only on rst.
- Reset asserted mid-frame: everything returns to reset values immediately. The remainder of the interrupted frame is treated as new frames (its bits typically set frame_err); this is acceptable.
- The receive path never drives the ps2 pins; there is no host-to-device transmit.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3.
  - PS2_BUS_BASE 24'hffffdx, so the decoder and this block agree on the address range.
- One natural sub-module: sync_fifo_byte. It is a parameterised FIFO_AW byte FIFO with push, pop, full, empty, count and a head output. The top level holds the synchroniser, FSM and timeout counter.

Test Plan:
- Single frame:
  - Stimulus: frame start=0, data 8'h1C LSB-first, parity=0, stop=1, at 10 kHz ps2_clk.
  - Response: ready=1 and key=8'h1C one clk after the stop fall. A 1-cycle rd pulse then gives ready=0 and key=8'h00 on the next clk.
- Parity error:
  - Stimulus: 8'h1C sent with parity=1.
  - Response: ready stays 0, frame_err=1, overflow=0. A following valid 8'hF0 frame is then received with key=8'hF0.
- Overflow:
  - Stimulus: send 9 valid frames 8'h01–8'h09 with no reads.
  - Response: overflow=1. Eight rd pulses return 8'h01–8'h08 in order, then ready=0.
- Held read:
  - Stimulus: queue 8'hAA and 8'hBB, then hold rd high for 20 cycles.
  - Response: exactly one pop; key=8'hBB and ready=1 while rd is held.
- Timeout:
  - Stimulus: start bit plus 4 data bits, then ps2_clk idle for longer than TIMEOUT cycles.
  - Response: FSM returns to IDLE and frame_err=1. The next full frame 8'h5A is received correctly.
- Reset mid-frame:
  - Stimulus: pulse rst after 3 data bits.
  - Response: ready=0, key=0, overflow=0 immediately, and the FIFO is empty.
